// File: rtl/fir_flex_pkg.sv
// ---------------------------------------------------------------------------
// fir_flex_pkg
// Shared definitions for the Flex FIR control path: FSM state encoding,
// default geometry of the coefficient SRAM banks, and a helper that gives
// the number of words fetched per accepted sample.
// No ports (package).
// ---------------------------------------------------------------------------
package fir_flex_pkg;

  localparam int FSM_STATE_W = 3;

  typedef enum logic [FSM_STATE_W-1:0] {
    IDLE   = 3'd0,
    UPDATE = 3'd1,
    WAIT   = 3'd2,
    READ   = 3'd3,
    DRAIN  = 3'd4
  } fsm_state_e;

  localparam int DEF_NUM_BANK      = 4;
  localparam int DEF_TAPS_PER_BANK = 10;
  localparam int DEF_ADDR_W        = 4;
  localparam int DEF_BANK_W        = 2;

  // Words fetched per sample: one bank's worth when all banks are read side
  // by side, every bank's worth when they are read one after another.
  function automatic int seqLength(input int taps, input int banks, input bit serial);
    return serial ? taps * banks : taps;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer_if
// Bundles the sequencer's control inputs and its SRAM/accumulator outputs.
//   master : used by the sequencer (drives oCsn..oOverrun)
//   slave  : used by the surrounding datapath (drives the strobe/update flag)
// Signals:
//   iEnSample600k  one-cycle sample strobe
//   iUpdateFlag    coefficient update mode
//   oCsn/oWrn      per-bank chip select / write enable, active-low
//   oAddr          SRAM read address
//   oBankSel/oInSel bank/tap index of the word currently valid
//   oEnDelay/oAccEn/oEnOut/oBusy/oOverrun  datapath controls and status
// ---------------------------------------------------------------------------
interface fir_tap_sequencer_if
  import fir_flex_pkg::*;
#(
  parameter int NUM_BANK = DEF_NUM_BANK,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BANK_W   = DEF_BANK_W
);
  logic                iEnSample600k;
  logic                iUpdateFlag;
  logic [NUM_BANK-1:0] oCsn;
  logic [NUM_BANK-1:0] oWrn;
  logic [ADDR_W-1:0]   oAddr;
  logic [BANK_W-1:0]   oBankSel;
  logic [ADDR_W-1:0]   oInSel;
  logic                oEnDelay;
  logic                oAccEn;
  logic                oEnOut;
  logic                oBusy;
  logic                oOverrun;

  modport master (
    input  iEnSample600k, iUpdateFlag,
    output oCsn, oWrn, oAddr, oBankSel, oInSel,
           oEnDelay, oAccEn, oEnOut, oBusy, oOverrun
  );

  modport slave (
    output iEnSample600k, iUpdateFlag,
    input  oCsn, oWrn, oAddr, oBankSel, oInSel,
           oEnDelay, oAccEn, oEnOut, oBusy, oOverrun
  );
endinterface

// File: rtl/tap_addr_counter.sv
// ---------------------------------------------------------------------------
// tap_addr_counter
// Two-level (bank, address) word counter for the coefficient fetch.
// In parallel mode only the address counts; in serial mode the address is
// the inner loop and wraps to 0 as the bank index advances.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          synchronous clear to word 0 (wins over en_i)
//   en_i           advance to the next word
//   addr_o/bank_o  current word (registered)
//   bankNext_o     bank index the counter will hold after this edge
//   last_o         registered flag: current word is the final one
// ---------------------------------------------------------------------------
module tap_addr_counter
  import fir_flex_pkg::*;
#(
  parameter int NUM_BANK      = DEF_NUM_BANK,
  parameter int TAPS_PER_BANK = DEF_TAPS_PER_BANK,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int BANK_W        = DEF_BANK_W,
  parameter int SERIAL_BANKS  = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BANK_W-1:0] bank_o,
  output logic [BANK_W-1:0] bankNext_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS_PER_BANK - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANK - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              last_q, last_d;

  // Next word, plus a look-ahead last flag so the FSM can leave READ on the
  // very edge that finishes the final word without a comparator in its path.
  always_comb begin
    addr_d = addr_q;
    bank_d = bank_q;
    if (clr_i) begin
      addr_d = '0;
      bank_d = '0;
    end else if (en_i) begin
      if ((SERIAL_BANKS != 0) && (addr_q == LAST_ADDR)) begin
        addr_d = '0;
        bank_d = bank_q + BANK_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
    last_d = (addr_d == LAST_ADDR) && ((SERIAL_BANKS == 0) || (bank_d == LAST_BANK));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      bank_q <= '0;
      last_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
      last_q <= last_d;
    end
  end

  assign addr_o     = addr_q;
  assign bank_o     = bank_q;
  assign bankNext_o = bank_d;
  assign last_o     = last_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
// Per-sample control sequencer for the Flex FIR: on an accepted sample
// strobe it walks every coefficient word, drives the SRAM chip selects and
// the accumulator controls, pulses completion and flags dropped strobes.
// Ports:
//   iClk_12M  system clock, rising edge
//   iRsn      asynchronous active-low reset
//   bus       fir_tap_sequencer_if.master (strobe/update in, SRAM and
//             accumulator controls out); every output is registered
// ---------------------------------------------------------------------------
module fir_tap_sequencer
  import fir_flex_pkg::*;
#(
  parameter int NUM_BANK      = DEF_NUM_BANK,
  parameter int TAPS_PER_BANK = DEF_TAPS_PER_BANK,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int BANK_W        = DEF_BANK_W,
  parameter int SERIAL_BANKS  = 0
) (
  input  logic              iClk_12M,
  input  logic              iRsn,
  fir_tap_sequencer_if.master bus
);

  fsm_state_e          state_q, state_d;
  logic [NUM_BANK-1:0] csn_q, csn_d;
  logic [ADDR_W-1:0]   inSel_q, inSel_d;
  logic [BANK_W-1:0]   bankSel_q, bankSel_d;
  logic                enDelay_q, enDelay_d;
  logic                accEn_q, accEn_d;
  logic                enOut_q, enOut_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  logic                cntClr, cntEn, cntLast;
  logic [ADDR_W-1:0]   cntAddr;
  logic [BANK_W-1:0]   cntBank, cntBankNext;

  // The counter register doubles as oAddr: it is held at 0 whenever the
  // FSM is not going to be in READ, so it is 0 outside READ for free.
  tap_addr_counter #(
    .NUM_BANK      (NUM_BANK),
    .TAPS_PER_BANK (TAPS_PER_BANK),
    .ADDR_W        (ADDR_W),
    .BANK_W        (BANK_W),
    .SERIAL_BANKS  (SERIAL_BANKS)
  ) uCounter (
    .clk_i      (iClk_12M),
    .rst_ni     (iRsn),
    .clr_i      (cntClr),
    .en_i       (cntEn),
    .addr_o     (cntAddr),
    .bank_o     (cntBank),
    .bankNext_o (cntBankNext),
    .last_o     (cntLast)
  );

  // Next-state logic. enOut_q marks the first WAIT cycle after DRAIN; a
  // strobe there belongs to the sample just missed, so it must not start
  // a fresh sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.iUpdateFlag) state_d = UPDATE;
      UPDATE: if (!bus.iUpdateFlag) state_d = WAIT;
      WAIT: begin
        if (bus.iUpdateFlag)                         state_d = UPDATE;
        else if (bus.iEnSample600k && !enOut_q)      state_d = READ;
      end
      READ: begin
        if (bus.iUpdateFlag)  state_d = UPDATE;
        else if (cntLast)     state_d = DRAIN;
      end
      DRAIN:  state_d = bus.iUpdateFlag ? UPDATE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values. Everything is decoded from the transition about to
  // happen so the registered outputs line up with the state they describe.
  always_comb begin
    cntClr    = (state_d != READ);
    cntEn     = (state_q == READ) && (state_d == READ);

    csn_d = '1;
    if (state_d == READ) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        csn_d[b] = !((SERIAL_BANKS == 0) || (cntBankNext == BANK_W'(b)));
      end
    end

    // The word presented this cycle comes back from the SRAM next cycle.
    accEn_d   = (state_q == READ) && (state_d != UPDATE);
    inSel_d   = accEn_d ? cntAddr : inSel_q;
    bankSel_d = accEn_d ? cntBank : bankSel_q;

    enDelay_d = (state_q == WAIT)  && (state_d == READ);
    enOut_d   = (state_q == DRAIN) && (state_d == WAIT);
    busy_d    = (state_d == READ)  || (state_d == DRAIN);

    // Entering UPDATE clears the flag and takes priority over a strobe
    // dropped in the same cycle.
    overrun_d = overrun_q;
    if ((state_d == UPDATE) && (state_q != UPDATE)) begin
      overrun_d = 1'b0;
    end else if (bus.iEnSample600k &&
                 ((state_q == READ) || (state_q == DRAIN) ||
                  ((state_q == WAIT) && enOut_q))) begin
      overrun_d = 1'b1;
    end
  end

  // State and output registers; reset leaves the SRAM deselected.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= IDLE;
      csn_q     <= '1;
      inSel_q   <= '0;
      bankSel_q <= '0;
      enDelay_q <= 1'b0;
      accEn_q   <= 1'b0;
      enOut_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      csn_q     <= csn_d;
      inSel_q   <= inSel_d;
      bankSel_q <= bankSel_d;
      enDelay_q <= enDelay_d;
      accEn_q   <= accEn_d;
      enOut_q   <= enOut_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // The write path owns the SRAM write strobes; this block only reads.
  assign bus.oWrn     = '1;
  assign bus.oCsn     = csn_q;
  assign bus.oAddr    = cntAddr;
  assign bus.oInSel   = inSel_q;
  assign bus.oBankSel = bankSel_q;
  assign bus.oEnDelay = enDelay_q;
  assign bus.oAccEn   = accEn_q;
  assign bus.oEnOut   = enOut_q;
  assign bus.oBusy    = busy_q;
  assign bus.oOverrun = overrun_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer
// Self-checking bench: one parallel-fetch and one serial-fetch sequencer.
// Expected accumulator words are queued when a strobe is driven and popped
// whenever a DUT raises oAccEn; per-cycle control outputs are compared
// against a vector table and hand-written sequences.
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;
  import fir_flex_pkg::*;

  localparam int NB  = DEF_NUM_BANK;
  localparam int TPB = DEF_TAPS_PER_BANK;
  localparam int AW  = DEF_ADDR_W;
  localparam int BW  = DEF_BANK_W;
  localparam int LP  = seqLength(TPB, NB, 1'b0);
  localparam int LS  = seqLength(TPB, NB, 1'b1);

  localparam logic [12:0] RST_OBS = {5'b00000, 4'hF, 4'h0};

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [AW-1:0] tap;
  } word_t;

  typedef struct {
    logic        s;
    logic        u;
    bit          push;
    logic [12:0] exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  rstN;
  int    checks = 0;
  int    failures = 0;
  logic  expOv = 1'b0;
  word_t expP[$];
  word_t expS[$];
  vec_t  vecs[13];

  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.NUM_BANK(NB), .ADDR_W(AW), .BANK_W(BW)) busP ();
  fir_tap_sequencer_if #(.NUM_BANK(NB), .ADDR_W(AW), .BANK_W(BW)) busS ();

  fir_tap_sequencer #(
    .NUM_BANK(NB), .TAPS_PER_BANK(TPB), .ADDR_W(AW), .BANK_W(BW), .SERIAL_BANKS(0)
  ) dutP (
    .iClk_12M (clk),
    .iRsn     (rstN),
    .bus      (busP)
  );

  fir_tap_sequencer #(
    .NUM_BANK(NB), .TAPS_PER_BANK(TPB), .ADDR_W(AW), .BANK_W(BW), .SERIAL_BANKS(1)
  ) dutS (
    .iClk_12M (clk),
    .iRsn     (rstN),
    .bus      (busS)
  );

  // Packs the cycle-level controls into one word so a whole cycle is one compare.
  function automatic logic [12:0] pk(input logic busy, input logic enDelay,
                                     input logic enOut, input logic accEn,
                                     input logic ov, input logic [3:0] csn,
                                     input logic [3:0] addr);
    return {busy, enDelay, enOut, accEn, ov, csn, addr};
  endfunction

  function automatic logic [12:0] obs(input bit serial);
    if (serial)
      return pk(busS.oBusy, busS.oEnDelay, busS.oEnOut, busS.oAccEn, busS.oOverrun, busS.oCsn, busS.oAddr);
    return pk(busP.oBusy, busP.oEnDelay, busP.oEnOut, busP.oAccEn, busP.oOverrun, busP.oCsn, busP.oAddr);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit serial, input logic s, input logic u);
    if (serial) begin
      busS.iEnSample600k = s;
      busS.iUpdateFlag   = u;
    end else begin
      busP.iEnSample600k = s;
      busP.iUpdateFlag   = u;
    end
  endtask

  // Queue the words the accumulator must see for one accepted sample.
  task automatic pushWords(input bit serial);
    if (serial) begin
      for (int k = 0; k < LS; k++) expS.push_back(word_t'{BW'(k / TPB), AW'(k % TPB)});
    end else begin
      for (int k = 0; k < LP; k++) expP.push_back(word_t'{BW'(0), AW'(k)});
    end
  endtask

  // Scoreboard side: every oAccEn cycle must match the next queued word.
  always @(negedge clk) begin
    word_t w;
    if (rstN === 1'b1) begin
      if (busP.oAccEn) begin
        if (expP.size() == 0) checkOutput("accP_extra", 1, 0);
        else begin
          w = expP.pop_front();
          checkOutput("accP_word", {busP.oBankSel, busP.oInSel}, w);
        end
      end
      if (busS.oAccEn) begin
        if (expS.size() == 0) checkOutput("accS_extra", 1, 0);
        else begin
          w = expS.pop_front();
          checkOutput("accS_word", {busS.oBankSel, busS.oInSel}, w);
        end
      end
    end
  end

  // One parallel sample starting now (cycle t). x: cycle of an extra strobe,
  // a: cycle iUpdateFlag is raised (0 = none). Checks cycles t+1..t+LP+4.
  task automatic runParSeq(input int x, input int a);
    logic ovStart = expOv;
    logic ab, inRead, ov;
    int   left;
    applyStimulus(0, 1'b1, 1'b0);
    pushWords(0);
    for (int c = 1; c <= LP + 4; c++) begin
      @(negedge clk);
      ab     = (a > 0) && (c > a);
      inRead = !ab && (c >= 1) && (c <= LP);
      ov     = ab ? 1'b0 : (ovStart || ((x > 0) && (c > x)));
      checkOutput($sformatf("par_x%0d_a%0d_c%0d", x, a, c), obs(0),
                  pk(!ab && (c <= LP + 1), c == 1, !ab && (c == LP + 2),
                     (c >= 2) && (c <= LP + 1) && ((a == 0) || (c <= a)),
                     ov, inRead ? 4'h0 : 4'hF, inRead ? 4'(c - 1) : 4'h0));
      applyStimulus(0, c == x, c == a);
      expOv = ov;
    end
    left = (a > 0) ? LP - ((a - 1 > LP) ? LP : a - 1) : 0;
    checkOutput($sformatf("par_left_a%0d", a), expP.size(), left);
    expP.delete();
  endtask

  initial begin
    // Vector table: {strobe, update, push words, expected controls after the edge}.
    vecs[0]  = '{1'b1, 1'b0, 0, RST_OBS};
    vecs[1]  = '{1'b0, 1'b0, 0, RST_OBS};
    vecs[2]  = '{1'b1, 1'b0, 0, RST_OBS};
    vecs[3]  = '{1'b0, 1'b1, 0, RST_OBS};
    vecs[4]  = '{1'b1, 1'b1, 0, RST_OBS};
    vecs[5]  = '{1'b0, 1'b0, 0, RST_OBS};
    vecs[6]  = '{1'b1, 1'b1, 0, RST_OBS};
    vecs[7]  = '{1'b0, 1'b0, 0, RST_OBS};
    vecs[8]  = '{1'b1, 1'b0, 1, pk(1, 1, 0, 0, 0, 4'h0, 4'h0)};
    vecs[9]  = '{1'b0, 1'b0, 0, pk(1, 0, 0, 1, 0, 4'h0, 4'h1)};
    vecs[10] = '{1'b1, 1'b0, 0, pk(1, 0, 0, 1, 1, 4'h0, 4'h2)};
    vecs[11] = '{1'b0, 1'b1, 0, RST_OBS};
    vecs[12] = '{1'b0, 1'b0, 0, RST_OBS};

    rstN = 1'b0;
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("resetP", obs(0), RST_OBS);
    checkOutput("resetS", obs(1), RST_OBS);
    checkOutput("resetWrn", {busP.oWrn, busS.oWrn}, 8'hFF);
    checkOutput("resetSel", {busP.oBankSel, busP.oInSel}, 0);
    rstN = 1'b1;
    @(negedge clk);

    // Table: idle strobes ignored, update handshake, coincident strobe/update,
    // start of a sequence with a dropped strobe, abort from READ.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, vecs[i].s, vecs[i].u);
      if (vecs[i].push) pushWords(0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), obs(0), vecs[i].exp);
    end
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("vec_abortLeft", expP.size(), LP - 2);
    expP.delete();

    // Multi-cycle corner cases on the parallel sequencer.
    runParSeq(0, 0);
    checkOutput("inSelHoldP", {busP.oBankSel, busP.oInSel}, {2'd0, 4'(TPB - 1)});
    runParSeq(0, 4);
    runParSeq(LP + 2, 0);
    runParSeq(0, LP + 1);
    runParSeq(5, 0);
    applyStimulus(0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ovClearOnUpdate", obs(0), RST_OBS);
    applyStimulus(0, 1'b0, 1'b0);
    @(negedge clk);

    // Serial fetch: bank-by-bank chip selects, four banks of TPB words.
    applyStimulus(1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0);
    pushWords(1);
    for (int c = 1; c <= LS + 3; c++) begin
      logic [3:0] one;
      logic       inRead;
      one    = 4'b0001;
      inRead = (c <= LS);
      @(negedge clk);
      checkOutput($sformatf("ser_c%0d", c), obs(1),
                  pk(c <= LS + 1, c == 1, c == LS + 2, (c >= 2) && (c <= LS + 1), 1'b0,
                     inRead ? ~(one << ((c - 1) / TPB)) : 4'hF,
                     inRead ? 4'((c - 1) % TPB) : 4'h0));
      applyStimulus(1, 1'b0, 1'b0);
    end
    checkOutput("ser_left", expS.size(), 0);
    checkOutput("inSelHoldS", {busS.oBankSel, busS.oInSel}, {2'd3, 4'(TPB - 1)});

    // Asynchronous reset in the middle of READ, then strobe before/after update.
    applyStimulus(0, 1'b1, 1'b0);
    pushWords(0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncResetP", obs(0), RST_OBS);
    checkOutput("asyncResetSel", {busP.oBankSel, busP.oInSel}, 0);
    expP.delete();
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("strobeIgnoredAfterReset", obs(0), RST_OBS);
    applyStimulus(0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0);
    pushWords(0);
    @(negedge clk);
    checkOutput("restartAfterUpdate", obs(0), pk(1, 1, 0, 0, 0, 4'h0, 4'h0));
    applyStimulus(0, 1'b0, 1'b0);
    repeat (LP + 2) @(negedge clk);
    checkOutput("restart_left", expP.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
